// File: rtl/t07_wb_arb_pkg.sv
// t07_wb_arb_pkg: shared FSM/grant types, the DEADBEEF fill word and default address windows
package t07_wb_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic {GNT_FETCH, GNT_DATA} gnt_t;
  localparam logic [31:0] DEADBEEF = 32'hDEADBEEF;
  localparam logic [7:0] DEF_ADDR_PREFIX = 8'h33;
  localparam logic [31:0] DEF_INSTR_MAX = 32'd1024;
  localparam logic [31:0] DEF_DATA_LO = 32'd1056;
  localparam logic [31:0] DEF_DATA_HI = 32'd1792;
  localparam logic [7:0] DEF_TIMEOUT_CYCLES = 8'd255;
  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] lo_excl, input logic [31:0] hi);
    return addr > lo_excl && addr <= hi;
  endfunction
endpackage

// File: rtl/t07_wb_watchdog.sv
// t07_wb_watchdog: counts cycles while a bus op is outstanding and flags when LIMIT is reached
module t07_wb_watchdog #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic clk,
  input  logic nrst,
  input  logic run,
  output logic expired
);
  logic [7:0] cnt;
  always_ff @(posedge clk) begin
    if (!nrst) cnt <= '0;
    else cnt <= run ? cnt + 8'd1 : '0;
  end
  // fires in the LIMIT-th running cycle so DONE lands exactly LIMIT cycles after ISSUE entry
  assign expired = run && cnt == LIMIT - 8'd1;
endmodule

// File: rtl/t07_wb_arbiter.sv
// t07_wb_arbiter: round-robin share of one Wishbone manager between fetch and data requesters.
// Define T07_WB_TIMEOUT_EN to add the bus watchdog (error + DEADBEEF after TIMEOUT_CYCLES).
module t07_wb_arbiter
  import t07_wb_arb_pkg::*;
#(
  parameter logic [7:0]  ADDR_PREFIX    = DEF_ADDR_PREFIX,
  parameter logic [31:0] INSTR_MAX      = DEF_INSTR_MAX,
  parameter logic [31:0] DATA_LO        = DEF_DATA_LO,
  parameter logic [31:0] DATA_HI        = DEF_DATA_HI,
  parameter logic [7:0]  TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        fetch_req_i,
  input  logic [31:0] fetch_addr_i,
  output logic        fetch_ack_o,
  output logic [31:0] instr_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_ack_o,
  output logic [31:0] data_rdata_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        WB_read_o,
  output logic        WB_write_o,
  output logic [31:0] addr_out,
  output logic [31:0] WBData_out,
  input  logic [31:0] WBData_i,
  input  logic        WB_busy_i
);
  state_t state, state_next;
  gnt_t gnt, pick;
  logic we, err, timeout, any_req, pick_ok;
  logic [31:0] pick_addr, rdata;
  assign any_req = fetch_req_i | data_req_i;
  // gnt doubles as the last-grant register: on a conflict the other requester wins
  assign pick = (data_req_i && (!fetch_req_i || gnt == GNT_FETCH)) ? GNT_DATA : GNT_FETCH;
  assign pick_addr = pick == GNT_DATA ? data_addr_i : fetch_addr_i;
  assign pick_ok = pick == GNT_DATA ? in_window(pick_addr, DATA_LO, DATA_HI) : pick_addr <= INSTR_MAX;
`ifdef T07_WB_TIMEOUT_EN
  t07_wb_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk(clk),
    .nrst(nrst),
    .run(state == ISSUE || state == WAIT),
    .expired(timeout)
  );
`else
  assign timeout = &{1'b0, TIMEOUT_CYCLES};
`endif
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = any_req ? ISSUE : IDLE;
      ISSUE:   state_next = (err || timeout) ? DONE : WB_busy_i ? WAIT : ISSUE;
      WAIT:    state_next = (timeout || !WB_busy_i) ? DONE : WAIT;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
      gnt <= GNT_FETCH;
      we <= 1'b0;
      err <= 1'b0;
      addr_out <= DEADBEEF;
      WBData_out <= DEADBEEF;
      rdata <= DEADBEEF;
    end else begin
      state <= state_next;
      if (state == IDLE && any_req) begin
        gnt <= pick;
        we <= pick == GNT_DATA && data_we_i;
        err <= !pick_ok;
        addr_out <= {ADDR_PREFIX, pick_addr[23:0]};
        rdata <= DEADBEEF;
        if (pick == GNT_DATA && data_we_i) WBData_out <= data_wdata_i;
      end else if (timeout) begin
        err <= 1'b1;
        rdata <= DEADBEEF;
      end else if (state == WAIT && !WB_busy_i) rdata <= WBData_i;
    end
  end
  // range errors spend their ISSUE cycle with strobes gated, so they never reach the bus
  assign WB_read_o = state == ISSUE && !err && !timeout && !we;
  assign WB_write_o = state == ISSUE && !err && !timeout && we;
  assign fetch_ack_o = state == DONE && gnt == GNT_FETCH;
  assign data_ack_o = state == DONE && gnt == GNT_DATA;
  assign err_o = state == DONE && err;
  assign busy_o = state != IDLE;
  assign instr_o = rdata;
  assign data_rdata_o = rdata;
endmodule

// File: tb/tb_t07_wb_arbiter.sv
// tb_t07_wb_arbiter: scoreboard bench with random requesters, a random-latency bus responder
// and a reference built from the address-window and round-robin rules.
module tb_t07_wb_arbiter;
  import t07_wb_arb_pkg::*;
  logic clk = 0, nrst = 0;
  logic fetch_req_i = 0, data_req_i = 0, data_we_i = 0, WB_busy_i = 0;
  logic [31:0] fetch_addr_i = 0, data_addr_i = 0, data_wdata_i = 0, WBData_i = 0;
  logic fetch_ack_o, data_ack_o, err_o, busy_o, WB_read_o, WB_write_o;
  logic [31:0] instr_o, data_rdata_o, addr_out, WBData_out;
  always #5 clk = ~clk;
  t07_wb_arbiter dut (
    .clk(clk), .nrst(nrst),
    .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i), .fetch_ack_o(fetch_ack_o), .instr_o(instr_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_ack_o(data_ack_o), .data_rdata_o(data_rdata_o), .err_o(err_o), .busy_o(busy_o),
    .WB_read_o(WB_read_o), .WB_write_o(WB_write_o), .addr_out(addr_out), .WBData_out(WBData_out),
    .WBData_i(WBData_i), .WB_busy_i(WB_busy_i)
  );
  typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata; logic err;} exp_t;
  typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata; logic [31:0] rdata;} bus_t;
  exp_t exp_f[$], exp_d[$];
  bus_t bus_log[$];
  int ack_order[$];
  int checks = 0, errors = 0, strobe_cnt = 0, last_served = 0;
  int dir_k = -1, dir_m = -1;
  bit resp_en = 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask
  task automatic score(input bit d);
    exp_t e;
    bus_t b;
    logic [31:0] rd;
    rd = d ? data_rdata_o : instr_o;
    ack_order.push_back(int'(d));
    last_served = int'(d);
    if ((d ? exp_d.size() : exp_f.size()) == 0) begin
      chk(d ? "unexpected_data_ack" : "unexpected_fetch_ack", 1, 0);
      return;
    end
    e = d ? exp_d.pop_front() : exp_f.pop_front();
    chk("err_o", 32'(err_o), 32'(e.err));
    if (e.err) begin
      chk("err_rdata", rd, DEADBEEF);
      chk("err_no_bus", bus_log.size(), 0);
    end else if (bus_log.size() == 0) chk("missing_bus_op", 1, 0);
    else begin
      b = bus_log.pop_front();
      chk("bus_addr", b.addr, {8'h33, e.addr[23:0]});
      chk("bus_we", 32'(b.we), 32'(e.we));
      if (e.we) chk("bus_wdata", b.wdata, e.wdata);
      else chk("rdata", rd, b.rdata);
    end
  endtask
  always @(negedge clk) begin
    if (WB_read_o || WB_write_o) strobe_cnt++;
    if (nrst && (fetch_ack_o || data_ack_o)) begin
      chk("one_ack", 32'(fetch_ack_o & data_ack_o), 0);
      chk("busy_at_ack", 32'(busy_o), 1);
      if (fetch_ack_o) score(0);
      if (data_ack_o) score(1);
    end
  end
  initial begin
    bus_t b;
    int k, m;
    forever begin
      @(negedge clk);
      if (resp_en && nrst && (WB_read_o || WB_write_o)) begin
        b.addr = addr_out;
        b.we = WB_write_o;
        b.wdata = WBData_out;
        b.rdata = $urandom;
        chk("one_strobe", 32'(WB_read_o & WB_write_o), 0);
        k = dir_k >= 0 ? dir_k : int'($urandom_range(0, 2));
        m = dir_m > 0 ? dir_m : int'($urandom_range(1, 3));
        repeat (k) begin
          @(negedge clk);
          chk("strobe_held", 32'(WB_read_o | WB_write_o), 1);
        end
        WB_busy_i = 1;
        repeat (m) begin
          @(negedge clk);
          chk("strobe_low_wait", 32'(WB_read_o | WB_write_o), 0);
        end
        WB_busy_i = 0;
        WBData_i = b.rdata;
        bus_log.push_back(b);
      end
    end
  end
  task automatic fetch_txn(input logic [31:0] a, input bit xe, output int lat);
    exp_t e;
    e.addr = a; e.we = 0; e.wdata = 0; e.err = xe || a > 32'd1024;
    exp_f.push_back(e);
    fetch_addr_i = a;
    fetch_req_i = 1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!fetch_ack_o && lat < 400);
    chk("fetch_ack_seen", 32'(fetch_ack_o), 1);
    @(posedge clk); #1;
    fetch_req_i = 0;
  endtask
  task automatic data_txn(input logic [31:0] a, input bit w, input logic [31:0] wd, output int lat);
    exp_t e;
    e.addr = a; e.we = w; e.wdata = wd; e.err = !(a > 32'd1056 && a <= 32'd1792);
    exp_d.push_back(e);
    data_addr_i = a;
    data_we_i = w;
    data_wdata_i = wd;
    data_req_i = 1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!data_ack_o && lat < 400);
    chk("data_ack_seen", 32'(data_ack_o), 1);
    @(posedge clk); #1;
    data_req_i = 0;
  endtask
  task automatic pair(input logic [31:0] fa, input logic [31:0] da);
    int l1, l2, first;
    first = 1 - last_served;
    ack_order.delete();
    @(negedge clk);
    fork
      fetch_txn(fa, 0, l1);
      data_txn(da, 0, 0, l2);
    join
    chk("arb_count", ack_order.size(), 2);
    if (ack_order.size() >= 2) begin
      chk("arb_first", ack_order[0], first);
      chk("arb_second", ack_order[1], 1 - first);
    end
  endtask
  function automatic logic [31:0] rand_addr(input bit d);
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return $urandom;
    if (r == 1) return d ? $urandom_range(0, 1056) : $urandom_range(1025, 4000);
    return d ? $urandom_range(1057, 1792) : $urandom_range(0, 1024);
  endfunction
  initial begin
    int lat, s0;
    logic [31:0] fb [3];
    logic [31:0] db [5];
    fb = '{32'd0, 32'd1024, 32'd1025};
    db = '{32'd1056, 32'd1057, 32'd1792, 32'd1793, 32'h3300_0500};
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 32'({fetch_ack_o, data_ack_o, err_o, busy_o, WB_read_o, WB_write_o}), 0);
    chk("rst_addr_out", addr_out, DEADBEEF);
    chk("rst_wbdata_out", WBData_out, DEADBEEF);
    chk("rst_instr", instr_o, DEADBEEF);
    chk("rst_rdata", data_rdata_o, DEADBEEF);
    nrst = 1;
    pair(32'h20, 32'h480);
    pair(32'h24, 32'h484);
    @(negedge clk);
    dir_k = 0; dir_m = 3; s0 = strobe_cnt;
    fetch_txn(32'h10, 0, lat);
    chk("fetch_latency", lat, 5);
    chk("fetch_one_strobe", strobe_cnt - s0, 1);
    @(negedge clk);
    dir_m = 1;
    data_txn(32'h600, 0, 0, lat);
    chk("min_latency", lat, 3);
    dir_k = -1; dir_m = -1;
    data_txn(32'h500, 1, 32'hCAFEF00D, lat);
    pair(32'h28, 32'h488);
    @(negedge clk);
    s0 = strobe_cnt;
    data_txn(32'h410, 0, 0, lat);
    chk("err_latency", lat, 2);
    chk("err_no_strobe", strobe_cnt - s0, 0);
    foreach (fb[i]) fetch_txn(fb[i], 0, lat);
    foreach (db[i]) data_txn(db[i], i[0], $urandom, lat);
    @(negedge clk);
    resp_en = 0;
    data_addr_i = 32'h600; data_we_i = 0; data_req_i = 1;
    @(negedge clk);
    chk("rst_pre_strobe", 32'(WB_read_o), 1);
    WB_busy_i = 1;
    @(negedge clk);
    chk("rst_pre_wait", 32'({busy_o, WB_read_o, WB_write_o}), 32'b100);
    nrst = 0; data_req_i = 0;
    @(negedge clk);
    chk("rst_mid_ctrl", 32'({fetch_ack_o, data_ack_o, err_o, busy_o, WB_read_o, WB_write_o}), 0);
    chk("rst_mid_addr", addr_out, DEADBEEF);
    nrst = 1; WB_busy_i = 0; resp_en = 1; last_served = 0;
    @(negedge clk);
    chk("rst_after_ctrl", 32'({fetch_ack_o, data_ack_o, busy_o}), 0);
    data_txn(32'h700, 0, 0, lat);
    fork
      for (int i = 0; i < 30; i++) begin
        int l;
        fetch_txn(rand_addr(0), 0, l);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      for (int j = 0; j < 30; j++) begin
        int l;
        data_txn(rand_addr(1), 1'($urandom_range(0, 1)), $urandom, l);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    join
`ifdef T07_WB_TIMEOUT_EN
    @(negedge clk);
    resp_en = 0; WB_busy_i = 1;
    fetch_txn(32'h8, 1, lat);
    chk("timeout_latency", lat, 32'(DEF_TIMEOUT_CYCLES) + 1);
    WB_busy_i = 0; resp_en = 1;
`endif
    repeat (4) @(negedge clk);
    chk("exp_f_drained", exp_f.size(), 0);
    chk("exp_d_drained", exp_d.size(), 0);
    chk("bus_log_drained", bus_log.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
